// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W stage (P) and the
// multiply/divide result queue (M), with a one-cycle pipeline stall to bound M starvation.
module grf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_a3,
    input  logic [31:0] m_wd,
    input  logic [31:0] m_pc,
    output logic        stall_p,
    output logic        m_pending,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, FORCE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;

    logic [4:0]         a3_mem [DEPTH];
    logic [31:0]        wd_mem [DEPTH];
    logic [31:0]        pc_mem [DEPTH];

    logic               full, hv, pv, push, pop, grant_p, grant_m;

    assign full      = (count == CNT_W'(DEPTH));
    assign hv        = (count != '0);
    assign pv        = p_we && (p_a3 != 5'd0);
    assign m_ready   = rst_n && !full;
    assign push      = m_valid && m_ready && (m_a3 != 5'd0);
    assign pop       = grant_m;
    assign stall_p   = (state == FORCE);
    assign m_pending = hv;

    always_comb begin
        state_nxt    = NORMAL;
        grant_p      = 1'b0;
        grant_m      = 1'b0;
        wait_cnt_nxt = wait_cnt;
        if (state == FORCE) begin
            grant_m = hv;
        end else begin
            grant_p = pv;
            grant_m = !pv && hv;
            if (hv && pv) begin
                if (wait_cnt == WAIT_W'(STARVE_LIMIT - 1))
                    state_nxt = FORCE;
                if (wait_cnt < WAIT_W'(STARVE_LIMIT))
                    wait_cnt_nxt = wait_cnt + 1'b1;
            end
        end
        // A pop or an empty queue means nobody is waiting any more.
        if (grant_m || !hv)
            wait_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a3_mem[wr_ptr] <= m_a3;
            wd_mem[wr_ptr] <= m_wd;
            pc_mem[wr_ptr] <= m_pc;
        end
    end

    // Output stage: registered write port, fields hold when no grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grf_we <= 1'b0;
            grf_a3 <= 5'd0;
            grf_wd <= 32'd0;
            grf_pc <= 32'd0;
        end else begin
            grf_we <= grant_p || grant_m;
            if (grant_p) begin
                grf_a3 <= p_a3;
                grf_wd <= p_wd;
                grf_pc <= p_pc;
            end else if (grant_m) begin
                grf_a3 <= a3_mem[rd_ptr];
                grf_wd <= wd_mem[rd_ptr];
                grf_pc <= pc_mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed-vector bench for grf_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd, p_pc;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;
    logic        stall_p, m_pending;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;

    int n_tests = 0;
    int n_fail  = 0;

    grf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
        .stall_p(stall_p), .m_pending(m_pending),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p(input logic we, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        p_we = we; p_a3 = a3; p_wd = wd; p_pc = pc;
    endtask

    task automatic set_m(input logic v, input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        m_valid = v; m_a3 = a3; m_wd = wd; m_pc = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        set_p(1'b0, 5'd0, 32'd0, 32'd0);
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        #3;
        chk("rst_grf_we", grf_we, 0);
        chk("rst_grf_a3", grf_a3, 0);
        chk("rst_grf_wd", grf_wd, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_m_pending", m_pending, 0);
        chk("rst_stall", stall_p, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_m_ready", m_ready, 1);

        // P write: one-cycle latency
        set_p(1'b1, 5'd5, 32'h1234, 32'h3000);
        tick();
        chk("p_we", grf_we, 1);
        chk("p_a3", grf_a3, 5);
        chk("p_wd", grf_wd, 32'h1234);
        chk("p_pc", grf_pc, 32'h3000);

        // M write with P idle: pending after push, written one cycle later
        set_p(1'b0, 5'd0, 32'd0, 32'd0);
        set_m(1'b1, 5'd8, 32'hAA, 32'h4000);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        chk("m1_pending", m_pending, 1);
        chk("m1_no_same_cycle", grf_we, 0);
        tick();
        chk("m1_we", grf_we, 1);
        chk("m1_a3", grf_a3, 8);
        chk("m1_wd", grf_wd, 32'hAA);
        chk("m1_pc", grf_pc, 32'h4000);
        chk("m1_pending_clr", m_pending, 0);

        // P write to $0 does not block the queued M entry
        set_m(1'b1, 5'd9, 32'h99, 32'h4004);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        set_p(1'b1, 5'd0, 32'h55, 32'h5000);
        tick();
        chk("p0_m_we", grf_we, 1);
        chk("p0_m_a3", grf_a3, 9);
        chk("p0_m_wd", grf_wd, 32'h99);
        chk("p0_stall", stall_p, 0);
        set_p(1'b0, 5'd0, 32'd0, 32'd0);

        // M push to $0 completes the handshake but stores nothing
        set_m(1'b1, 5'd0, 32'hDEAD, 32'h4008);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        chk("m0_pending", m_pending, 0);
        tick();
        chk("m0_we", grf_we, 0);
        chk("m0_hold_a3", grf_a3, 9);

        // Starvation: head denied while wait_cnt = 0,1,2,3, forced on the next cycle
        set_p(1'b1, 5'd3, 32'h100, 32'h6000);
        set_m(1'b1, 5'd10, 32'hBB, 32'h4010);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        chk("sv_push_p_a3", grf_a3, 3);
        chk("sv_push_stall", stall_p, 0);
        for (int i = 1; i <= 4; i++) begin
            p_wd = 32'h100 + i;
            tick();
            chk($sformatf("sv_deny%0d_a3", i), grf_a3, 3);
            chk($sformatf("sv_deny%0d_wd", i), grf_wd, 32'h100 + i);
            chk($sformatf("sv_deny%0d_stall", i), stall_p, (i == 4) ? 1 : 0);
        end
        p_wd = 32'h1FF;
        tick();
        chk("sv_force_a3", grf_a3, 10);
        chk("sv_force_wd", grf_wd, 32'hBB);
        chk("sv_force_stall_off", stall_p, 0);
        chk("sv_force_pending", m_pending, 0);
        p_wd = 32'h200;
        tick();
        chk("sv_resume_a3", grf_a3, 3);
        chk("sv_resume_wd", grf_wd, 32'h200);

        // Fill queue while P busy, back-pressure, then drain in order
        set_p(1'b1, 5'd4, 32'h300, 32'h7000);
        set_m(1'b1, 5'd11, 32'hC1, 32'h4020);
        tick();
        chk("fill1_ready", m_ready, 1);
        set_m(1'b1, 5'd12, 32'hC2, 32'h4024);
        tick();
        chk("fill2_ready", m_ready, 0);
        chk("fill2_pending", m_pending, 1);
        set_m(1'b1, 5'd13, 32'hC3, 32'h4028);
        tick();
        chk("held_ready", m_ready, 0);
        chk("held_p_a3", grf_a3, 4);
        set_p(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("drain1_a3", grf_a3, 11);
        chk("drain1_wd", grf_wd, 32'hC1);
        chk("drain1_ready", m_ready, 1);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        chk("drain2_a3", grf_a3, 12);
        chk("drain2_pc", grf_pc, 32'h4024);
        tick();
        chk("drain3_a3", grf_a3, 13);
        chk("drain3_wd", grf_wd, 32'hC3);
        chk("drain3_pending", m_pending, 0);

        // Asynchronous reset with two entries queued
        set_p(1'b1, 5'd6, 32'h400, 32'h8000);
        set_m(1'b1, 5'd14, 32'hD1, 32'h4030);
        tick();
        set_m(1'b1, 5'd15, 32'hD2, 32'h4034);
        tick();
        set_m(1'b0, 5'd0, 32'd0, 32'd0);
        chk("pre_rst_pending", m_pending, 1);
        chk("pre_rst_we", grf_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", grf_we, 0);
        chk("arst_a3", grf_a3, 0);
        chk("arst_pc", grf_pc, 0);
        chk("arst_pending", m_pending, 0);
        chk("arst_ready", m_ready, 0);
        set_p(1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_arst%0d_we", i), grf_we, 0);
            chk($sformatf("post_arst%0d_pending", i), m_pending, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
